// File: rtl/fft_sink_pkg.sv
// Shared types and constants for the FFT frame sink.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_sink_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    DROP   = 2'd2,
    COMMIT = 2'd3
  } sink_state_t;

  // Beat-to-bank-write latency of the power pipeline.
  localparam int PIPE_LAT = 3;

  // Power word width: a sum of two N-bit signed squares never exceeds 2N+1 bits.
  function automatic int pwr_width(input int n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/fft_power_pipe.sv
// Per-bin power re^2+im^2, with write address and last-bin flag carried alongside.
// Latency: 3 cycles from in_vld to out_vld (S1 register, S2 square, S3 sum).
// Backpressure: none; accepts one sample per cycle, output must be consumed.
// Ports: clk/rst; in_vld/in_last/in_re/in_im/in_addr; out_vld/out_last/out_addr/out_pwr.
module fft_power_pipe #(
  parameter int N     = 18,
  parameter int AW    = 3,
  parameter int PWR_W = 2 * N + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_last,
  input  logic [N-1:0]     in_re,
  input  logic [N-1:0]     in_im,
  input  logic [AW-1:0]    in_addr,
  output logic             out_vld,
  output logic             out_last,
  output logic [AW-1:0]    out_addr,
  output logic [PWR_W-1:0] out_pwr
);
  localparam int SQ_W = 2 * N;

  logic                   s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic signed [N-1:0]    s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [AW-1:0]          s1_addr_q, s1_addr_d;
  logic                   s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic signed [SQ_W-1:0] s2_re_sq_q, s2_re_sq_d, s2_im_sq_q, s2_im_sq_d;
  logic [AW-1:0]          s2_addr_q, s2_addr_d;
  logic                   s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
  logic [PWR_W-1:0]       s3_pwr_q, s3_pwr_d;
  logic [AW-1:0]          s3_addr_q, s3_addr_d;

  always_comb begin
    s1_vld_d   = in_vld;
    s1_last_d  = in_last;
    s1_re_d    = in_re;
    s1_im_d    = in_im;
    s1_addr_d  = in_addr;
    // Operands are sign-extended to 2N before multiplying; the most negative
    // input squares to 2^(2N-2), which is still positive in 2N signed bits.
    s2_re_sq_d = SQ_W'(s1_re_q) * SQ_W'(s1_re_q);
    s2_im_sq_d = SQ_W'(s1_im_q) * SQ_W'(s1_im_q);
    s2_vld_d   = s1_vld_q;
    s2_last_d  = s1_last_q;
    s2_addr_d  = s1_addr_q;
    // Squares are non-negative, so zero-extension is exact.
    s3_pwr_d   = PWR_W'($unsigned(s2_re_sq_q)) + PWR_W'($unsigned(s2_im_sq_q));
    s3_vld_d   = s2_vld_q;
    s3_last_d  = s2_last_q;
    s3_addr_d  = s2_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0; s1_last_q <= 1'b0; s1_re_q <= '0; s1_im_q <= '0; s1_addr_q <= '0;
      s2_vld_q <= 1'b0; s2_last_q <= 1'b0; s2_re_sq_q <= '0; s2_im_sq_q <= '0; s2_addr_q <= '0;
      s3_vld_q <= 1'b0; s3_last_q <= 1'b0; s3_pwr_q <= '0; s3_addr_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d; s1_last_q <= s1_last_d; s1_re_q <= s1_re_d; s1_im_q <= s1_im_d;
      s1_addr_q <= s1_addr_d;
      s2_vld_q <= s2_vld_d; s2_last_q <= s2_last_d; s2_re_sq_q <= s2_re_sq_d;
      s2_im_sq_q <= s2_im_sq_d; s2_addr_q <= s2_addr_d;
      s3_vld_q <= s3_vld_d; s3_last_q <= s3_last_d; s3_pwr_q <= s3_pwr_d; s3_addr_q <= s3_addr_d;
    end
  end

  assign out_vld  = s3_vld_q;
  assign out_last = s3_last_q;
  assign out_addr = s3_addr_q;
  assign out_pwr  = s3_pwr_q;

endmodule

// File: rtl/fft_frame_sink.sv
// FFT result sink: per-bin power into a ping-pong frame buffer, handed to a random-access reader.
// Latency: bin written 3 cycles after its beat; FRAME_READY 4 cycles after the last beat; RD_DATA 1 cycle after RD_ADDR.
// Backpressure: none toward the FFT; a frame arriving while its target bank is still held is dropped and counted.
// Ports: CLK_125MHZ_FPGA/SCLR; FFT side XK_RE, XK_IM, BLK_EXP, FD_OUT, DATA_VALID;
//        reader side FRAME_READY, FRAME_BANK, FRAME_EXP, RD_ADDR, RD_DATA, RD_DONE; status OVERFLOW_CNT, FRAME_ERR.
module fft_frame_sink
  import fft_sink_pkg::*;
#(
  parameter int N      = 18,
  parameter int NFFT   = 4,
  parameter int ADDR_W = $clog2(NFFT),
  parameter int PWR_W  = pwr_width(N)
) (
  input  logic              CLK_125MHZ_FPGA,
  input  logic              SCLR,
  input  logic [N-1:0]      XK_RE,
  input  logic [N-1:0]      XK_IM,
  input  logic [3:0]        BLK_EXP,
  input  logic              FD_OUT,
  input  logic              DATA_VALID,
  output logic              FRAME_READY,
  output logic              FRAME_BANK,
  output logic [3:0]        FRAME_EXP,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [PWR_W-1:0]  RD_DATA,
  input  logic              RD_DONE,
  output logic [7:0]        OVERFLOW_CNT,
  output logic              FRAME_ERR
);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NFFT - 1);

  sink_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        full_q, full_d;      // bank holds a committed frame
  logic [1:0]        pend_q, pend_d;      // bank's last bin accepted, pipeline still draining
  logic [1:0][3:0]   exp_q, exp_d;
  logic              err_q, err_d;
  logic [7:0]        ovf_q, ovf_d;
  logic              frame_ready_q, frame_ready_d;
  logic [3:0]        frame_exp_q, frame_exp_d;
  logic [PWR_W-1:0]  rd_data_q, rd_data_d;
  logic              commit_vld_q, commit_vld_d, commit_bank_q, commit_bank_d;
  logic              wr_busy;

  logic              pipe_vld, pipe_last;
  logic [ADDR_W:0]   pipe_addr;
  logic              pw_vld, pw_last;
  logic [ADDR_W:0]   pw_addr;
  logic [PWR_W-1:0]  pw_pwr;

  // Bank bit is the address MSB of a single buffer.
  logic [PWR_W-1:0]  mem [0:2*NFFT-1];

  fft_power_pipe #(.N(N), .AW(ADDR_W + 1), .PWR_W(PWR_W)) u_pipe (
    .clk      (CLK_125MHZ_FPGA),
    .rst      (SCLR),
    .in_vld   (pipe_vld),
    .in_last  (pipe_last),
    .in_re    (XK_RE),
    .in_im    (XK_IM),
    .in_addr  (pipe_addr),
    .out_vld  (pw_vld),
    .out_last (pw_last),
    .out_addr (pw_addr),
    .out_pwr  (pw_pwr)
  );

  always_ff @(posedge CLK_125MHZ_FPGA) begin
    if (pw_vld) mem[pw_addr] <= pw_pwr;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    full_d        = full_q;
    pend_d        = pend_q;
    exp_d         = exp_q;
    err_d         = err_q;
    ovf_d         = ovf_q;
    pipe_vld      = 1'b0;
    pipe_last     = 1'b0;
    pipe_addr     = {wr_ptr_q, cnt_q};
    // The commit fires one cycle after the last bin's write, so the bank is
    // fully written before anyone can read it.
    commit_vld_d  = pw_vld & pw_last;
    commit_bank_d = pw_addr[ADDR_W];
    wr_busy       = full_q[wr_ptr_q] | pend_q[wr_ptr_q];

    if (RD_DONE && frame_ready_q) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    if (commit_vld_q) begin
      full_d[commit_bank_q] = 1'b1;
      pend_d[commit_bank_q] = 1'b0;
    end

    case (state_q)
      FILL: if (DATA_VALID) begin
        pipe_vld = 1'b1;
        if (FD_OUT) begin
          // Unexpected frame start: restart in the same bank.
          err_d            = 1'b1;
          exp_d[wr_ptr_q]  = BLK_EXP;
          pipe_addr        = {wr_ptr_q, {ADDR_W{1'b0}}};
          cnt_d            = ADDR_W'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIN) begin
            // Advance the write pointer now so a back-to-back frame targets
            // the other bank; the pending flag keeps this bank reserved.
            pipe_last        = 1'b1;
            pend_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
            state_d          = COMMIT;
          end
        end
      end
      DROP: if (DATA_VALID && !FD_OUT) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIN) state_d = IDLE;
      end
      COMMIT: if (commit_vld_q) state_d = IDLE;
      default: ;
    endcase

    // Frame start outside FILL (IDLE, DROP or COMMIT).
    if (state_q != FILL && DATA_VALID && FD_OUT) begin
      cnt_d = ADDR_W'(1);
      if (!wr_busy) begin
        state_d         = FILL;
        exp_d[wr_ptr_q] = BLK_EXP;
        pipe_vld        = 1'b1;
        pipe_addr       = {wr_ptr_q, {ADDR_W{1'b0}}};
      end else begin
        state_d = DROP;
        if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
      end
    end

    // Frames are written and read in alternating banks, so rd_ptr always
    // names the oldest frame.
    frame_ready_d = full_d[rd_ptr_d];
    frame_exp_d   = frame_ready_d ? exp_q[rd_ptr_d] : frame_exp_q;
    rd_data_d     = frame_ready_q ? mem[{rd_ptr_q, RD_ADDR}] : rd_data_q;
  end

  always_ff @(posedge CLK_125MHZ_FPGA or posedge SCLR) begin
    if (SCLR) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      full_q        <= '0;
      pend_q        <= '0;
      exp_q         <= '0;
      err_q         <= 1'b0;
      ovf_q         <= '0;
      frame_ready_q <= 1'b0;
      frame_exp_q   <= '0;
      rd_data_q     <= '0;
      commit_vld_q  <= 1'b0;
      commit_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      full_q        <= full_d;
      pend_q        <= pend_d;
      exp_q         <= exp_d;
      err_q         <= err_d;
      ovf_q         <= ovf_d;
      frame_ready_q <= frame_ready_d;
      frame_exp_q   <= frame_exp_d;
      rd_data_q     <= rd_data_d;
      commit_vld_q  <= commit_vld_d;
      commit_bank_q <= commit_bank_d;
    end
  end

  assign FRAME_READY  = frame_ready_q;
  assign FRAME_BANK   = rd_ptr_q;
  assign FRAME_EXP    = frame_exp_q;
  assign RD_DATA      = rd_data_q;
  assign OVERFLOW_CNT = ovf_q;
  assign FRAME_ERR    = err_q;

endmodule

// File: tb/tb_fft_frame_sink.sv
// Bench for fft_frame_sink: scoreboard of expected bin powers, one task per scenario.
// Latency: n/a.
// Backpressure: n/a.
module tb_fft_frame_sink;
  localparam int N      = 18;
  localparam int NFFT   = 4;
  localparam int ADDR_W = 2;
  localparam int PWR_W  = 37;

  logic              clk = 1'b0;
  logic              SCLR;
  logic [N-1:0]      XK_RE, XK_IM;
  logic [3:0]        BLK_EXP;
  logic              FD_OUT, DATA_VALID;
  logic              FRAME_READY, FRAME_BANK;
  logic [3:0]        FRAME_EXP;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [PWR_W-1:0]  RD_DATA;
  logic              RD_DONE;
  logic [7:0]        OVERFLOW_CNT;
  logic              FRAME_ERR;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PWR_W-1:0] sb[$];

  int         tre[8];
  int         tim[8];
  int         tgap[8];
  logic [3:0] texp[8];

  always #4 clk = ~clk;

  fft_frame_sink #(.N(N), .NFFT(NFFT)) dut (
    .CLK_125MHZ_FPGA (clk),
    .SCLR            (SCLR),
    .XK_RE           (XK_RE),
    .XK_IM           (XK_IM),
    .BLK_EXP         (BLK_EXP),
    .FD_OUT          (FD_OUT),
    .DATA_VALID      (DATA_VALID),
    .FRAME_READY     (FRAME_READY),
    .FRAME_BANK      (FRAME_BANK),
    .FRAME_EXP       (FRAME_EXP),
    .RD_ADDR         (RD_ADDR),
    .RD_DATA         (RD_DATA),
    .RD_DONE         (RD_DONE),
    .OVERFLOW_CNT    (OVERFLOW_CNT),
    .FRAME_ERR       (FRAME_ERR)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_beats();
    for (int i = 0; i < 8; i++) begin
      tre[i] = 0; tim[i] = 0; tgap[i] = 0; texp[i] = 4'd0;
    end
  endtask

  // Drives n beats from the stimulus arrays; beats flagged in push are expected in the stored frame.
  task automatic send_beats(input int n, input logic [7:0] fd, input logic [7:0] push);
    longint p;
    for (int i = 0; i < n; i++) begin
      XK_RE      = tre[i][N-1:0];
      XK_IM      = tim[i][N-1:0];
      BLK_EXP    = texp[i];
      FD_OUT     = fd[i];
      DATA_VALID = 1'b1;
      if (push[i]) begin
        p = longint'(tre[i]) * longint'(tre[i]) + longint'(tim[i]) * longint'(tim[i]);
        sb.push_back(p[PWR_W-1:0]);
      end
      tick();
      DATA_VALID = 1'b0;
      FD_OUT     = 1'b0;
      for (int g = 0; g < tgap[i]; g++) tick();
    end
  endtask

  // Waits for a frame, checks bank/exponent, reads all bins against the scoreboard, releases the bank.
  task automatic read_frame(input logic bank, input logic [3:0] bexp, input string name);
    int k;
    logic [PWR_W-1:0] e;
    k = 0;
    while (FRAME_READY !== 1'b1 && k < 60) begin
      tick();
      k++;
    end
    n_tests++;
    if (FRAME_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got %b want 1 (timeout)", name, FRAME_READY);
    end
    n_tests++;
    if (FRAME_BANK !== bank) begin
      n_fail++;
      $display("FAIL %s_bank: got %b want %b", name, FRAME_BANK, bank);
    end
    n_tests++;
    if (FRAME_EXP !== bexp) begin
      n_fail++;
      $display("FAIL %s_exp: got %0d want %0d", name, FRAME_EXP, bexp);
    end
    for (int i = 0; i < NFFT; i++) begin
      RD_ADDR = ADDR_W'(i);
      tick();
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      n_tests++;
      if (RD_DATA !== e) begin
        n_fail++;
        $display("FAIL %s_bin%0d: got %0d want %0d", name, i, RD_DATA, e);
      end
    end
    RD_DONE = 1'b1;
    tick();
    RD_DONE = 1'b0;
  endtask

  task automatic test_reset();
    SCLR = 1'b1; XK_RE = '0; XK_IM = '0; BLK_EXP = '0; FD_OUT = 1'b0; DATA_VALID = 1'b0;
    RD_ADDR = '0; RD_DONE = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({FRAME_READY, FRAME_BANK, FRAME_EXP, RD_DATA, OVERFLOW_CNT, FRAME_ERR} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b bank=%b exp=%0d data=%0d ovf=%0d err=%b want all 0",
               FRAME_READY, FRAME_BANK, FRAME_EXP, RD_DATA, OVERFLOW_CNT, FRAME_ERR);
    end
    SCLR = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    clear_beats();
    for (int i = 0; i < 4; i++) tre[i] = i;
    texp[0] = 4'd2;
    send_beats(4, 8'h01, 8'h0F);
    repeat (3) tick();
    n_tests++;
    if (FRAME_READY !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_ready: got %b want 0 three cycles after last beat", FRAME_READY);
    end
    tick();
    n_tests++;
    if (FRAME_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready_lat: got %b want 1 four cycles after last beat", FRAME_READY);
    end
    read_frame(1'b0, 4'd2, "basic");
  endtask

  task automatic test_extreme();
    clear_beats();
    tre[0] = -3;      tim[0] = 4;
    tre[1] = -131072; tim[1] = -131072;
    tre[2] = 131071;  tim[2] = -7;
    tre[3] = -1;      tim[3] = 0;
    texp[0] = 4'd7;
    send_beats(4, 8'h01, 8'h0F);
    read_frame(1'b1, 4'd7, "extreme");
  endtask

  task automatic test_gapped();
    clear_beats();
    tre[0] = 10; tre[1] = -20; tre[2] = 30; tre[3] = -40;
    tim[0] = 1;  tim[1] = 2;   tim[2] = 3;  tim[3] = 4;
    tgap[0] = 1; tgap[1] = 5;
    texp[0] = 4'd4;
    send_beats(4, 8'h01, 8'h0F);
    read_frame(1'b0, 4'd4, "gapped");
  endtask

  // Three back-to-back frames with both banks held: the third is dropped.
  task automatic test_overflow();
    clear_beats();
    for (int i = 0; i < 4; i++) tre[i] = i + 1;
    texp[0] = 4'd1;
    send_beats(4, 8'h01, 8'h0F);
    for (int i = 0; i < 4; i++) tre[i] = i + 5;
    texp[0] = 4'd2;
    send_beats(4, 8'h01, 8'h0F);
    for (int i = 0; i < 4; i++) tre[i] = 100 + i;
    texp[0] = 4'd3;
    send_beats(4, 8'h01, 8'h00);
    repeat (6) tick();
    n_tests++;
    if (OVERFLOW_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d want 1", OVERFLOW_CNT);
    end
    read_frame(1'b1, 4'd1, "ovf_f1");
    n_tests++;
    if ({FRAME_READY, FRAME_BANK} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovf_next_bank: got rdy=%b bank=%b want rdy=1 bank=0", FRAME_READY, FRAME_BANK);
    end
    for (int i = 0; i < 4; i++) begin
      tre[i] = -(i + 1);
      tim[i] = 3;
    end
    texp[0] = 4'd6;
    send_beats(4, 8'h01, 8'h0F);
    read_frame(1'b0, 4'd2, "ovf_f2");
    read_frame(1'b1, 4'd6, "ovf_f4");
    n_tests++;
    if (OVERFLOW_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL ovf_count_after: got %0d want 1", OVERFLOW_CNT);
    end
  endtask

  task automatic test_restart();
    clear_beats();
    tre[0] = 99; tre[1] = 98; tre[2] = 1; tre[3] = 2; tre[4] = 3; tre[5] = 4;
    texp[0] = 4'd9;
    texp[2] = 4'd5;
    send_beats(6, 8'b0000_0101, 8'b0011_1100);
    n_tests++;
    if (FRAME_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_err: got %b want 1", FRAME_ERR);
    end
    read_frame(1'b0, 4'd5, "restart");
  endtask

  task automatic test_reset_midfill();
    clear_beats();
    tre[0] = 50; tre[1] = 51;
    texp[0] = 4'd8;
    send_beats(2, 8'h01, 8'h00);
    SCLR = 1'b1;
    #1;
    n_tests++;
    if ({FRAME_READY, FRAME_BANK, FRAME_EXP, RD_DATA, OVERFLOW_CNT, FRAME_ERR} !== '0) begin
      n_fail++;
      $display("FAIL midfill_reset: got rdy=%b bank=%b exp=%0d data=%0d ovf=%0d err=%b want all 0",
               FRAME_READY, FRAME_BANK, FRAME_EXP, RD_DATA, OVERFLOW_CNT, FRAME_ERR);
    end
    tick();
    SCLR = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if ({FRAME_READY, FRAME_BANK, FRAME_EXP, RD_DATA, OVERFLOW_CNT, FRAME_ERR} !== '0) begin
        n_fail++;
        $display("FAIL midfill_quiet%0d: got rdy=%b bank=%b exp=%0d data=%0d ovf=%0d err=%b want all 0",
                 c, FRAME_READY, FRAME_BANK, FRAME_EXP, RD_DATA, OVERFLOW_CNT, FRAME_ERR);
      end
    end
    clear_beats();
    tre[0] = 7; tre[1] = -8; tre[2] = 9; tre[3] = -10;
    tim[0] = 1; tim[1] = 1;  tim[2] = 1; tim[3] = 1;
    texp[0] = 4'd3;
    send_beats(4, 8'h01, 8'h0F);
    read_frame(1'b0, 4'd3, "midfill");
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extreme();
    test_gapped();
    test_overflow();
    test_restart();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
